// File: rtl/yarp_wb_arbiter.sv
// Write-side front end of the YARP register file.
// Merges the ALU result stream (through a small FIFO) and the LSU load-return
// stream onto the single regfile write port. Load data is formatted here, and
// writes to x0 are dropped. A pending-load scoreboard drives the decode stall
// flags.
module yarp_wb_arbiter #(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        alu_valid_i,
    output logic        alu_ready_o,
    input  logic [4:0]  alu_rd_i,
    input  logic [31:0] alu_data_i,

    input  logic        lsu_valid_i,
    output logic        lsu_ready_o,
    input  logic [4:0]  lsu_rd_i,
    input  logic [31:0] lsu_rdata_i,
    input  logic [1:0]  lsu_byte_off_i,
    input  logic [1:0]  lsu_size_i,
    input  logic        lsu_zero_ext_i,

    input  logic        ld_issue_i,
    input  logic [4:0]  ld_issue_rd_i,

    input  logic [4:0]  rs1_addr_i,
    input  logic [4:0]  rs2_addr_i,
    output logic        rs1_busy_o,
    output logic        rs2_busy_o,

    output logic [4:0]  rd_addr_o,
    output logic        wr_en_o,
    output logic [31:0] wr_data_o
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

    // ALU result FIFO storage and bookkeeping
    logic [4:0]      fifo_rd_q   [FIFO_DEPTH];
    logic [31:0]     fifo_data_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic fifo_full, fifo_empty;
    logic push, pop;
    logic alu_grant, lsu_grant;

    // Registered regfile write port
    logic [4:0]  rd_addr_q, rd_addr_d;
    logic        wr_en_q, wr_en_d;
    logic [31:0] wr_data_q, wr_data_d;

    // Pending-load scoreboard, one bit per architectural register
    logic [31:0] busy_q, busy_d;

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_fmt;

    logic        grant_valid;
    logic [4:0]  grant_rd;
    logic [31:0] grant_data;

    // FIFO status, handshakes and arbitration
    always_comb begin
        fifo_full   = (count_q == CntFull);
        fifo_empty  = (count_q == '0);
        alu_ready_o = !fifo_full;
        lsu_ready_o = !fifo_full;
        push        = alu_valid_i & !fifo_full;
        // A full FIFO takes priority so the ALU side can never starve.
        lsu_grant   = !fifo_full & lsu_valid_i;
        alu_grant   = fifo_full | (!lsu_valid_i & !fifo_empty);
        pop         = alu_grant;
    end

    // Load data formatting by size, offset and sign
    always_comb begin
        ld_byte = lsu_rdata_i[{lsu_byte_off_i, 3'b000} +: 8];
        ld_half = lsu_byte_off_i[1] ? lsu_rdata_i[31:16] : lsu_rdata_i[15:0];
        unique case (lsu_size_i)
            2'b00:   ld_fmt = {{24{!lsu_zero_ext_i & ld_byte[7]}}, ld_byte};
            2'b01:   ld_fmt = {{16{!lsu_zero_ext_i & ld_half[15]}}, ld_half};
            default: ld_fmt = lsu_rdata_i;
        endcase
    end

    // Select the winning transaction
    always_comb begin
        grant_valid = alu_grant | lsu_grant;
        grant_rd    = '0;
        grant_data  = '0;
        if (alu_grant) begin
            grant_rd   = fifo_rd_q[rd_ptr_q];
            grant_data = fifo_data_q[rd_ptr_q];
        end else if (lsu_grant) begin
            grant_rd   = lsu_rd_i;
            grant_data = ld_fmt;
        end
    end

    // Next-state for FIFO pointers, output register and scoreboard
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        // Writes to x0 are consumed but never reach the regfile.
        wr_en_d   = grant_valid & (grant_rd != 5'd0);
        rd_addr_d = wr_en_d ? grant_rd   : rd_addr_q;
        wr_data_d = wr_en_d ? grant_data : wr_data_q;

        // Clear first so a same-cycle issue to the same rd stays pending.
        busy_d = busy_q;
        if (lsu_grant && (lsu_rd_i != 5'd0)) begin
            busy_d[lsu_rd_i] = 1'b0;
        end
        if (ld_issue_i && (ld_issue_rd_i != 5'd0)) begin
            busy_d[ld_issue_rd_i] = 1'b1;
        end
    end

    // FIFO entry storage; contents need no reset, the count guards them
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q]   <= alu_rd_i;
            fifo_data_q[wr_ptr_q] <= alu_data_i;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            wr_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            wr_en_q   <= wr_en_d;
            rd_addr_q <= rd_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
        end
    end

    // Outputs; busy_q[0] is never set so x0 always reads as free
    always_comb begin
        wr_en_o    = wr_en_q;
        rd_addr_o  = rd_addr_q;
        wr_data_o  = wr_data_q;
        rs1_busy_o = busy_q[rs1_addr_i];
        rs2_busy_o = busy_q[rs2_addr_i];
    end

endmodule

// File: tb/tb_yarp_wb_arbiter.sv
// Self-checking bench for yarp_wb_arbiter: directed scenarios plus a randomized
// run against a queue-based transaction model.
module tb_yarp_wb_arbiter;

    localparam int unsigned DEPTH = 2;

    logic        clk;
    logic        reset_n;
    logic        alu_valid_i;
    logic        alu_ready_o;
    logic [4:0]  alu_rd_i;
    logic [31:0] alu_data_i;
    logic        lsu_valid_i;
    logic        lsu_ready_o;
    logic [4:0]  lsu_rd_i;
    logic [31:0] lsu_rdata_i;
    logic [1:0]  lsu_byte_off_i;
    logic [1:0]  lsu_size_i;
    logic        lsu_zero_ext_i;
    logic        ld_issue_i;
    logic [4:0]  ld_issue_rd_i;
    logic [4:0]  rs1_addr_i;
    logic [4:0]  rs2_addr_i;
    logic        rs1_busy_o;
    logic        rs2_busy_o;
    logic [4:0]  rd_addr_o;
    logic        wr_en_o;
    logic [31:0] wr_data_o;

    yarp_wb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .alu_valid_i    (alu_valid_i),
        .alu_ready_o    (alu_ready_o),
        .alu_rd_i       (alu_rd_i),
        .alu_data_i     (alu_data_i),
        .lsu_valid_i    (lsu_valid_i),
        .lsu_ready_o    (lsu_ready_o),
        .lsu_rd_i       (lsu_rd_i),
        .lsu_rdata_i    (lsu_rdata_i),
        .lsu_byte_off_i (lsu_byte_off_i),
        .lsu_size_i     (lsu_size_i),
        .lsu_zero_ext_i (lsu_zero_ext_i),
        .ld_issue_i     (ld_issue_i),
        .ld_issue_rd_i  (ld_issue_rd_i),
        .rs1_addr_i     (rs1_addr_i),
        .rs2_addr_i     (rs2_addr_i),
        .rs1_busy_o     (rs1_busy_o),
        .rs2_busy_o     (rs2_busy_o),
        .rd_addr_o      (rd_addr_o),
        .wr_en_o        (wr_en_o),
        .wr_data_o      (wr_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: queued ALU results, pending-load set, expected write port
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_busy;
    logic        exp_wr_en;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;

    function automatic logic [31:0] fmt(input logic [31:0] w, input int off, input int size,
                                        input bit zext);
        logic [31:0] v;
        if (size == 0) begin
            v = (w >> (8 * off)) & 32'hFF;
            if (!zext && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (size == 1) begin
            v = (w >> (16 * (off / 2))) & 32'hFFFF;
            if (!zext && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic model_busy(input logic [4:0] r);
        return (r != 5'd0) && m_busy[r];
    endfunction

    // Advance the model by one clock using the inputs now applied, then clock the DUT
    task automatic tick();
        bit          full;
        bit          g;
        bit          lg;
        logic [4:0]  grd;
        logic [31:0] gd;
        ent_t        e;
        full = (m_q.size() == DEPTH);
        g = 0;
        lg = 0;
        grd = '0;
        gd = '0;
        if (!reset_n) begin
            m_q.delete();
            m_busy    = '0;
            exp_wr_en = 0;
            exp_rd    = '0;
            exp_data  = '0;
        end else begin
            if (full) begin
                g = 1;
                e = m_q.pop_front();
                grd = e.rd;
                gd = e.data;
            end else if (lsu_valid_i) begin
                g = 1;
                lg = 1;
                grd = lsu_rd_i;
                gd = fmt(lsu_rdata_i, int'(lsu_byte_off_i), int'(lsu_size_i), lsu_zero_ext_i);
            end else if (m_q.size() != 0) begin
                g = 1;
                e = m_q.pop_front();
                grd = e.rd;
                gd = e.data;
            end
            if (alu_valid_i && !full) begin
                e.rd = alu_rd_i;
                e.data = alu_data_i;
                m_q.push_back(e);
            end
            exp_wr_en = g && (grd != 5'd0);
            if (exp_wr_en) begin
                exp_rd = grd;
                exp_data = gd;
            end
            if (lg && grd != 5'd0) m_busy[grd] = 1'b0;
            if (ld_issue_i && ld_issue_rd_i != 5'd0) m_busy[ld_issue_rd_i] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid_i = 0; alu_rd_i = '0; alu_data_i = '0;
        lsu_valid_i = 0; lsu_rd_i = '0; lsu_rdata_i = '0;
        lsu_byte_off_i = '0; lsu_size_i = 2'b10; lsu_zero_ext_i = 0;
        ld_issue_i = 0; ld_issue_rd_i = '0;
        rs1_addr_i = '0; rs2_addr_i = '0;
    endtask

    task automatic test_reset();
        reset_n = 0;
        idle_inputs();
        tick();
        tick();
        reset_n = 1;
        #1;
        n_tests++;
        if (wr_en_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_wr_en: got %b want 0", wr_en_o);
        end
        n_tests++;
        if (rd_addr_o !== 5'd0 || wr_data_o !== 32'd0) begin
            n_fail++; $display("FAIL reset_port: got rd %0d data %h want 0/0", rd_addr_o, wr_data_o);
        end
        n_tests++;
        if (alu_ready_o !== 1'b1 || lsu_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got alu %b lsu %b want 1/1", alu_ready_o, lsu_ready_o);
        end
    endtask

    task automatic test_alu_only();
        alu_valid_i = 1; alu_rd_i = 5'd3; alu_data_i = 32'hDEADBEEF;
        tick();
        alu_valid_i = 0;
        n_tests++;
        if (wr_en_o !== 1'b0) begin
            n_fail++; $display("FAIL alu_no_bypass: got wr_en %b want 0", wr_en_o);
        end
        tick();
        n_tests++;
        if (wr_en_o !== 1'b1 || rd_addr_o !== 5'd3 || wr_data_o !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL alu_write: got %b/%0d/%h want 1/3/deadbeef", wr_en_o, rd_addr_o, wr_data_o);
        end
        tick();
        n_tests++;
        if (wr_en_o !== 1'b0 || rd_addr_o !== 5'd3 || wr_data_o !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL alu_one_cycle: got %b/%0d/%h want 0/3/deadbeef", wr_en_o, rd_addr_o, wr_data_o);
        end
    endtask

    task automatic test_load_format();
        logic [1:0]  offs  [6] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd3};
        logic [1:0]  sizes [6] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
        logic        zexts [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] wants [6] = '{32'hFFFFFF82, 32'h00000082, 32'h0000007F,
                                   32'hFFFF80F1, 32'h000080F1, 32'h80F17F82};
        for (int i = 0; i < 6; i++) begin
            lsu_valid_i = 1; lsu_rd_i = 5'd10; lsu_rdata_i = 32'h80F17F82;
            lsu_byte_off_i = offs[i]; lsu_size_i = sizes[i]; lsu_zero_ext_i = zexts[i];
            tick();
            n_tests++;
            if (wr_en_o !== 1'b1 || rd_addr_o !== 5'd10 || wr_data_o !== wants[i]) begin
                n_fail++;
                $display("FAIL load_fmt[%0d]: got %b/%0d/%h want 1/10/%h",
                         i, wr_en_o, rd_addr_o, wr_data_o, wants[i]);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_arbitration();
        // x0 load returns hold off ALU draining while the FIFO fills
        lsu_valid_i = 1; lsu_rd_i = 5'd0;
        alu_valid_i = 1; alu_rd_i = 5'd1; alu_data_i = 32'hA1A1A1A1;
        tick();
        alu_rd_i = 5'd2; alu_data_i = 32'hB2B2B2B2;
        tick();
        alu_valid_i = 0;
        lsu_rd_i = 5'd9; lsu_rdata_i = 32'h12345678; lsu_size_i = 2'b10;
        #1;
        n_tests++;
        if (lsu_ready_o !== 1'b0 || alu_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL arb_full_ready: got lsu %b alu %b want 0/0", lsu_ready_o, alu_ready_o);
        end
        tick();
        n_tests++;
        if (wr_en_o !== 1'b1 || rd_addr_o !== 5'd1 || wr_data_o !== 32'hA1A1A1A1) begin
            n_fail++; $display("FAIL arb_full_alu: got %b/%0d/%h want 1/1/a1a1a1a1", wr_en_o, rd_addr_o, wr_data_o);
        end
        n_tests++;
        if (lsu_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL arb_lsu_ready: got %b want 1", lsu_ready_o);
        end
        tick();
        lsu_valid_i = 0;
        n_tests++;
        if (wr_en_o !== 1'b1 || rd_addr_o !== 5'd9 || wr_data_o !== 32'h12345678) begin
            n_fail++; $display("FAIL arb_lsu_next: got %b/%0d/%h want 1/9/12345678", wr_en_o, rd_addr_o, wr_data_o);
        end
        tick();
        n_tests++;
        if (wr_en_o !== 1'b1 || rd_addr_o !== 5'd2 || wr_data_o !== 32'hB2B2B2B2) begin
            n_fail++; $display("FAIL arb_alu_tail: got %b/%0d/%h want 1/2/b2b2b2b2", wr_en_o, rd_addr_o, wr_data_o);
        end
        // One entry queued: a valid load return goes first
        lsu_valid_i = 1; lsu_rd_i = 5'd0;
        alu_valid_i = 1; alu_rd_i = 5'd4; alu_data_i = 32'h44444444;
        tick();
        alu_valid_i = 0; lsu_rd_i = 5'd11; lsu_rdata_i = 32'hCAFEF00D;
        tick();
        lsu_valid_i = 0;
        n_tests++;
        if (wr_en_o !== 1'b1 || rd_addr_o !== 5'd11 || wr_data_o !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL arb_lsu_first: got %b/%0d/%h want 1/11/cafef00d", wr_en_o, rd_addr_o, wr_data_o);
        end
        tick();
        n_tests++;
        if (wr_en_o !== 1'b1 || rd_addr_o !== 5'd4 || wr_data_o !== 32'h44444444) begin
            n_fail++; $display("FAIL arb_alu_after: got %b/%0d/%h want 1/4/44444444", wr_en_o, rd_addr_o, wr_data_o);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_scoreboard();
        ld_issue_i = 1; ld_issue_rd_i = 5'd7;
        tick();
        ld_issue_i = 0; rs1_addr_i = 5'd7; rs2_addr_i = 5'd7;
        #1;
        n_tests++;
        if (rs1_busy_o !== 1'b1 || rs2_busy_o !== 1'b1) begin
            n_fail++; $display("FAIL sb_set: got rs1 %b rs2 %b want 1/1", rs1_busy_o, rs2_busy_o);
        end
        // Return and a fresh issue to the same rd in one cycle
        lsu_valid_i = 1; lsu_rd_i = 5'd7; lsu_rdata_i = 32'h00000077; lsu_size_i = 2'b10;
        ld_issue_i = 1; ld_issue_rd_i = 5'd7;
        tick();
        ld_issue_i = 0;
        n_tests++;
        if (rs1_busy_o !== 1'b1) begin
            n_fail++; $display("FAIL sb_set_wins: got %b want 1", rs1_busy_o);
        end
        tick();
        lsu_valid_i = 0;
        n_tests++;
        if (rs1_busy_o !== 1'b0) begin
            n_fail++; $display("FAIL sb_clear: got %b want 0", rs1_busy_o);
        end
        n_tests++;
        if (wr_en_o !== 1'b1 || rd_addr_o !== 5'd7 || wr_data_o !== 32'h00000077) begin
            n_fail++; $display("FAIL sb_write: got %b/%0d/%h want 1/7/00000077", wr_en_o, rd_addr_o, wr_data_o);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_x0();
        alu_valid_i = 1; alu_rd_i = 5'd0; alu_data_i = 32'h11111111;
        lsu_valid_i = 1; lsu_rd_i = 5'd0; lsu_rdata_i = 32'h22222222;
        ld_issue_i = 1; ld_issue_rd_i = 5'd0;
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (wr_en_o !== 1'b0) begin
                n_fail++; $display("FAIL x0_no_write[%0d]: got %b want 0", i, wr_en_o);
            end
            tick();
        end
        n_tests++;
        if (rs1_busy_o !== 1'b0 || alu_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL x0_busy: got busy %b ready %b want 0/1", rs1_busy_o, alu_ready_o);
        end
    endtask

    task automatic test_reset_mid();
        lsu_valid_i = 1; lsu_rd_i = 5'd0;
        alu_valid_i = 1; alu_rd_i = 5'd20; alu_data_i = 32'h20202020;
        ld_issue_i = 1; ld_issue_rd_i = 5'd5;
        tick();
        ld_issue_i = 0;
        alu_rd_i = 5'd21; alu_data_i = 32'h21212121;
        tick();
        idle_inputs();
        rs1_addr_i = 5'd5;
        #1;
        n_tests++;
        if (alu_ready_o !== 1'b0 || rs1_busy_o !== 1'b1) begin
            n_fail++; $display("FAIL rmid_setup: got ready %b busy %b want 0/1", alu_ready_o, rs1_busy_o);
        end
        reset_n = 0;
        tick();
        reset_n = 1;
        #1;
        n_tests++;
        if (alu_ready_o !== 1'b1 || rs1_busy_o !== 1'b0 || wr_en_o !== 1'b0 || rd_addr_o !== 5'd0) begin
            n_fail++;
            $display("FAIL rmid_state: got ready %b busy %b wr_en %b rd %0d want 1/0/0/0",
                     alu_ready_o, rs1_busy_o, wr_en_o, rd_addr_o);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (wr_en_o !== 1'b0) begin
                n_fail++; $display("FAIL rmid_stale[%0d]: got %b want 0", i, wr_en_o);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            alu_valid_i    = ($urandom_range(0, 99) < 55);
            alu_rd_i       = 5'($urandom_range(0, 7));
            alu_data_i     = $urandom;
            lsu_valid_i    = ($urandom_range(0, 99) < 35);
            lsu_rd_i       = 5'($urandom_range(0, 7));
            lsu_rdata_i    = $urandom;
            lsu_byte_off_i = 2'($urandom_range(0, 3));
            lsu_size_i     = 2'($urandom_range(0, 3));
            lsu_zero_ext_i = 1'($urandom_range(0, 1));
            ld_issue_i     = ($urandom_range(0, 99) < 40);
            ld_issue_rd_i  = 5'($urandom_range(0, 7));
            rs1_addr_i     = 5'($urandom_range(0, 7));
            rs2_addr_i     = 5'($urandom_range(0, 31));
            #1;
            n_tests++;
            if (alu_ready_o !== (m_q.size() != DEPTH) || lsu_ready_o !== (m_q.size() != DEPTH)) begin
                n_fail++;
                $display("FAIL rand_ready[%0d]: got alu %b lsu %b want %b", c, alu_ready_o,
                         lsu_ready_o, (m_q.size() != DEPTH));
            end
            n_tests++;
            if (rs1_busy_o !== model_busy(rs1_addr_i) || rs2_busy_o !== model_busy(rs2_addr_i)) begin
                n_fail++;
                $display("FAIL rand_busy[%0d]: got %b/%b want %b/%b", c, rs1_busy_o, rs2_busy_o,
                         model_busy(rs1_addr_i), model_busy(rs2_addr_i));
            end
            tick();
            n_tests++;
            if (wr_en_o !== exp_wr_en || rd_addr_o !== exp_rd || wr_data_o !== exp_data) begin
                n_fail++;
                $display("FAIL rand_port[%0d]: got %b/%0d/%h want %b/%0d/%h", c, wr_en_o,
                         rd_addr_o, wr_data_o, exp_wr_en, exp_rd, exp_data);
            end
        end
        idle_inputs();
    endtask

    initial begin
        m_busy    = '0;
        exp_wr_en = 0;
        exp_rd    = '0;
        exp_data  = '0;
        test_reset();
        test_alu_only();
        test_load_format();
        test_arbitration();
        test_scoreboard();
        test_x0();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
